// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the shared sequential multiplier scheduler.
// Holds the FSM state encoding, the round-robin pick function and width helpers.
package seq_mult_pkg;

    // Upper bound on requester count supported by rr_pick.
    localparam int unsigned MaxR = 64;

    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StRun  = 2'd1;
    localparam state_t StResp = 2'd2;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } pick_t;

    function automatic int unsigned id_width(input int unsigned r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // First valid index at or after ptr, wrapping modulo r.
    function automatic pick_t rr_pick(input logic [MaxR-1:0] valid, input int unsigned ptr,
                                      input int unsigned r);
        pick_t       p;
        int unsigned k;
        p.found = 1'b0;
        p.idx   = '0;
        for (int unsigned i = 0; i < MaxR; i++) begin
            if (i < r) begin
                k = (ptr + i) % r;
                if (!p.found && valid[k]) begin
                    p.found = 1'b1;
                    p.idx   = k;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/seq_mult_sched_if.sv
// Request/response bundle between client blocks and the multiplier scheduler.
interface seq_mult_sched_if #(
    parameter int unsigned N = 4,
    parameter int unsigned R = 4
);
    localparam int unsigned IW = seq_mult_pkg::id_width(R);

    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_m;
    logic [R*N-1:0] req_q;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*N-1:0] rsp_prod;
    logic [IW-1:0]  rsp_id;

    modport master (
        output req_valid, req_m, req_q, rsp_ready,
        input  req_ready, rsp_valid, rsp_prod, rsp_id
    );

    modport slave (
        input  req_valid, req_m, req_q, rsp_ready,
        output req_ready, rsp_valid, rsp_prod, rsp_id
    );
endinterface

// File: rtl/seq_mult_core.sv
// Iterative unsigned shift-add multiplier datapath (Z/M/cnt).
// Optional macro SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier
// bits are all zero; the product is unchanged, only the step count shrinks.
module seq_mult_core import seq_mult_pkg::*; #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           step_i,
    input  logic [N-1:0]   m_i,
    input  logic [N-1:0]   q_i,
    output logic           done_o,
    output logic [2*N-1:0] prod_o
);
    localparam int unsigned ZW = 2 * N + 1;
    localparam int unsigned CW = cnt_width(N);

    logic [ZW-1:0] z_q, z_d, z_step, z_next;
    logic [N-1:0]  m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_step, cnt_next;
    logic          last;
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic          rest_zero;
`endif

    // One add/shift step; last flags the step that empties the counter.
    always_comb begin
        z_step = z_q;
        if (z_q[0]) begin
            z_step[2*N:N] = {1'b0, z_q[2*N-1:N]} + {1'b0, m_q};
        end
        z_step   = z_step >> 1;
        cnt_step = cnt_q - CW'(1);
        z_next   = z_step;
        cnt_next = cnt_step;
        last     = (cnt_step == '0);
`ifdef SEQ_MULT_EARLY_TERM_EN
        rest_zero = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            if ((i < int'(cnt_step)) && z_step[i]) begin
                rest_zero = 1'b0;
            end
        end
        // Remaining bits add nothing: apply the outstanding shifts in one go.
        if (rest_zero) begin
            z_next   = z_step >> cnt_step;
            cnt_next = '0;
            last     = 1'b1;
        end
`endif
    end

    // Load on start, advance on step, otherwise hold.
    always_comb begin
        z_d   = z_q;
        m_d   = m_q;
        cnt_d = cnt_q;
        if (start_i) begin
            z_d   = {{(N + 1){1'b0}}, q_i};
            m_d   = m_i;
            cnt_d = CW'(N);
        end else if (step_i) begin
            z_d   = z_next;
            cnt_d = cnt_next;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else begin
            z_q   <= z_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
        end
    end

    // done_o/prod_o describe the result of the step taken on the coming edge.
    assign done_o = step_i && last;
    assign prod_o = z_next[2*N-1:0];

endmodule

// File: rtl/seq_mult_sched.sv
// Round-robin scheduler sharing one sequential multiplier among R requesters.
// Holds the arbiter, IDLE/RUN/RESP FSM and response registers; datapath is seq_mult_core.
// Optional macro SEQ_MULT_EARLY_TERM_EN (handled in seq_mult_core) shortens RUN.
module seq_mult_sched import seq_mult_pkg::*; #(
    parameter int unsigned N = 4,
    parameter int unsigned R = 4
) (
    input logic             clk,
    input logic             rst,
    seq_mult_sched_if.slave bus
);
    localparam int unsigned IW = id_width(R);

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [2*N-1:0]  prod_q, prod_d;
    logic [MaxR-1:0] valid_ext;
    pick_t           pick;
    logic [IW-1:0]   grant;
    logic            accept;
    logic [N-1:0]    m_sel, q_sel;
    logic            core_done;
    logic [2*N-1:0]  core_prod;

    // Arbitration: only IDLE may grant, and only the picked port sees ready.
    always_comb begin
        valid_ext        = '0;
        valid_ext[R-1:0] = bus.req_valid;
        pick             = rr_pick(valid_ext, 32'(rr_ptr_q), R);
        grant            = IW'(pick.idx);
        accept           = (state_q == StIdle) && pick.found;
        m_sel            = bus.req_m[grant*N +: N];
        q_sel            = bus.req_q[grant*N +: N];
        bus.req_ready    = '0;
        if (accept) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    // FSM next state and response capture.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        prod_d   = prod_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StRun;
                    rr_ptr_d = IW'((pick.idx + 32'd1) % R);
                    id_d     = grant;
                end
            end
            StRun: begin
                if (core_done) begin
                    state_d = StResp;
                    prod_d  = core_prod;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and response registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            id_q     <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            prod_q   <= prod_d;
        end
    end

    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_prod  = prod_q;
    assign bus.rsp_id    = id_q;

    seq_mult_core #(
        .N(N)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept),
        .step_i  (state_q == StRun),
        .m_i     (m_sel),
        .q_i     (q_sel),
        .done_o  (core_done),
        .prod_o  (core_prod)
    );

endmodule

// File: tb/tb_seq_mult_sched.sv
// Directed self-checking bench for seq_mult_sched (N=4, R=4).
module tb_seq_mult_sched;
    localparam int unsigned N = 4;
    localparam int unsigned R = 4;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    seq_mult_sched_if #(.N(N), .R(R)) bus ();

    seq_mult_sched #(.N(N), .R(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] q);
`ifdef SEQ_MULT_EARLY_TERM_EN
        int h = 0;
        for (int i = 0; i < 4; i++) begin
            if (q[i]) h = i;
        end
        return h + 1;
`else
        return 4;
`endif
    endfunction

    task automatic set_ops(input int port, input logic [3:0] m, input logic [3:0] q);
        bus.req_m[port*N +: N] = m;
        bus.req_q[port*N +: N] = q;
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic start_req(input logic [3:0] mask, input logic [3:0] keep, input int exp_id,
                             input string tag);
        bus.req_valid = mask;
        #1;
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(1 << exp_id));
        @(negedge clk);
        bus.req_valid = keep;
    endtask

    task automatic wait_rsp(input string tag, input int lat, input int id, input int prod);
        int k = 0;
        while (bus.rsp_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
            chk({tag, " busy req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        chk({tag, " latency"}, 32'(k), 32'(lat));
        chk({tag, " rsp_prod"}, 32'(bus.rsp_prod), 32'(prod));
        chk({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(id));
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_m     = '0;
        bus.req_q     = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_prod", 32'(bus.rsp_prod), 32'd0);
        chk("reset rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("reset req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;

        // Round robin with every port valid: ids 0,1,2,3,0, prods 3,6,9,12,3.
        for (int k = 0; k < 4; k++) set_ops(k, 4'(k + 1), 4'd3);
        for (int i = 0; i < 5; i++) begin
            start_req(4'b1111, 4'b1111, i % 4, "rr");
            wait_rsp("rr", exp_lat(4'd3), i % 4, ((i % 4) + 1) * 3);
            @(negedge clk);
            chk("rr rsp_valid drop", 32'(bus.rsp_valid), 32'd0);
        end

        // 13 * 11 = 143 from port 0 (rr_ptr now 1, port 0 is the only valid one).
        set_ops(0, 4'd13, 4'd11);
        start_req(4'b0001, 4'b0000, 0, "basic");
        wait_rsp("basic", exp_lat(4'd11), 0, 143);
        @(negedge clk);
        chk("basic rsp_valid drop", 32'(bus.rsp_valid), 32'd0);

        // 15 * 15 = 225, exercises the carry into Z[2N].
        set_ops(1, 4'd15, 4'd15);
        start_req(4'b0010, 4'b0000, 1, "carry");
        wait_rsp("carry", exp_lat(4'd15), 1, 225);
        @(negedge clk);

        // Back-pressure: 7 * 6 = 42 held while rsp_ready is low and all ports request.
        set_ops(2, 4'd7, 4'd6);
        bus.rsp_ready = 1'b0;
        start_req(4'b0100, 4'b1111, 2, "stall");
        wait_rsp("stall", exp_lat(4'd6), 2, 42);
        repeat (5) begin
            @(negedge clk);
            chk("stall rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall rsp_prod", 32'(bus.rsp_prod), 32'd42);
            chk("stall rsp_id", 32'(bus.rsp_id), 32'd2);
            chk("stall req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall rsp_valid drop", 32'(bus.rsp_valid), 32'd0);
        #1;
        chk("stall next grant", 32'(bus.req_ready), 32'b1000);
        bus.req_valid = '0;

        // Reset on the second RUN cycle: no response, rr_ptr back to 0.
        set_ops(2, 4'd5, 4'd9);
        set_ops(3, 4'd2, 4'd2);
        start_req(4'b0100, 4'b0000, 2, "abort");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort rsp_prod", 32'(bus.rsp_prod), 32'd0);
        chk("abort rsp_id", 32'(bus.rsp_id), 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("abort no response", 32'(bus.rsp_valid), 32'd0);
        end
        start_req(4'b1100, 4'b0000, 2, "post reset");
        wait_rsp("post reset", exp_lat(4'd9), 2, 45);
        @(negedge clk);

        // 9 * 1 and 9 * 0: latency depends on early termination.
        set_ops(0, 4'd9, 4'd1);
        start_req(4'b0001, 4'b0000, 0, "q1");
        wait_rsp("q1", exp_lat(4'd1), 0, 9);
        @(negedge clk);
        set_ops(0, 4'd9, 4'd0);
        start_req(4'b0001, 4'b0000, 0, "q0");
        wait_rsp("q0", exp_lat(4'd0), 0, 0);
        @(negedge clk);
        chk("q0 rsp_valid drop", 32'(bus.rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
